log_memory_ctrl: RTL

Capture-and-readback controller for the debug log RAM. It sits directly downstream of the register file and consumes its `run_log`, `read_log` and log address controls. On a run command it fills a single-port-write, single-port-read RAM with one datapath word per valid sample, then flags full. It returns stored words through the register file's read-data path to the microprocessor GPI.

---
 rtl/log_memory_ctrl.sv | 56 +++++
 1 files changed

// File: rtl/log_memory_ctrl.sv
// log_memory_ctrl: captures one datapath word per valid sample into the log RAM on a run
// command, flags full after the last address, and returns stored words with one cycle of latency.
module log_memory_ctrl #(
  parameter int NB_ADD_MEM = 14,
  parameter int NB_DATA    = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_run_log,
  input  logic                  i_read_log,
  input  logic [NB_ADD_MEM-1:0] i_addr_log,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_valid,
  output logic [NB_DATA-1:0]    o_data_log,
  output logic                  o_mem_full,
  output logic                  o_logging
);
  typedef enum logic [1:0] {IDLE, LOGGING, FULL} state_t;
  state_t                state, state_nx;
  logic [NB_ADD_MEM-1:0] wr_ptr, wr_ptr_nx;
  logic                  run_prev, run_start, we;
  logic [NB_DATA-1:0]    mem [2**NB_ADD_MEM];
  assign run_start  = i_run_log & ~run_prev;
  assign o_logging  = state == LOGGING;
  assign o_mem_full = state == FULL;
  // the write that lands on the last address still completes if the run level drops with it
  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    we        = 1'b0;
    if (run_start) begin
      state_nx  = LOGGING;
      wr_ptr_nx = '0;
    end else if (state == LOGGING) begin
      we        = i_valid & (i_run_log | (&wr_ptr));
      wr_ptr_nx = we ? wr_ptr + 1'b1 : wr_ptr;
      state_nx  = (we & (&wr_ptr)) ? FULL : (i_run_log ? LOGGING : IDLE);
    end
  end
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      run_prev   <= 1'b0;
      o_data_log <= '0;
    end else begin
      state      <= state_nx;
      wr_ptr     <= wr_ptr_nx;
      run_prev   <= i_run_log;
      o_data_log <= i_read_log ? mem[i_addr_log] : o_data_log;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= i_data;
  end
endmodule
